// File: rtl/div_iter_if.sv
// div_iter_if -- request/response bundle of the iterative divider.
//   start    : request strobe (requester -> divider)
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : numerator, captured with start
//   divisor  : denominator, captured with start
//   kill     : synchronous flush of any operation in progress
//   busy     : divider is not idle
//   valid    : one-cycle result strobe
//   result   : registered quotient or remainder
`timescale 1ns/1ps
interface div_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            kill;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, kill,
    input  busy, valid, result
  );

  modport slave (
    input  start, op, dividend, divisor, kill,
    output busy, valid, result
  );
endinterface

// File: rtl/div_iter.sv
// div_iter -- iterative radix-2 restoring divider for the rv32im execute
// stage (DIV, DIVU, REM, REMU with RISC-V divide-by-zero and overflow rules).
// Ports:
//   ACLK  : clock, all state changes on its rising edge
//   RESET : asynchronous active-low reset
//   bus   : div_iter_if slave (start/op/dividend/divisor/kill in,
//           busy/valid/result out)
// A normal request spends 32 cycles in CALC, one in FIX and one in DONE;
// divide-by-zero and signed overflow go straight to DONE.
`timescale 1ns/1ps
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic       ACLK,
  input  logic       RESET,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] result_q;

  // Datapath registers (no reset; always loaded on accept before use).
  logic            sel_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] dvs_mag_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic is_signed, div_zero, ovf, accept;
  assign is_signed = ~bus.op[0];
  assign div_zero  = (bus.divisor == '0);
  assign ovf       = is_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.divisor == '1);
  assign accept    = (state_q == IDLE) && bus.start && !bus.kill;

  // One restoring step: the shifted partial remainder needs XLEN+1 bits,
  // but whatever is kept afterwards is below the divisor and fits XLEN.
  logic [XLEN:0]   shifted, diff;
  logic            step_ok;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_mag_q};
  assign step_ok = ~diff[XLEN];

  logic [XLEN-1:0] fix_result;
  assign fix_result = sel_rem_q ? cond_neg(rem_q, neg_rem_q)
                                : cond_neg(quo_q, neg_quo_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = (div_zero || ovf) ? DONE : CALC;
      CALC: if (count_q == CW'(XLEN-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.kill) state_d = IDLE;
  end

  always_ff @(posedge ACLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        count_q <= '0;
      else if (state_q == CALC && !bus.kill)
        count_q <= count_q + 1'b1;
      // Special cases resolve in the accept cycle; kill leaves result alone.
      if (accept && div_zero)
        result_q <= bus.op[1] ? bus.dividend : '1;
      else if (accept && ovf)
        result_q <= bus.op[1] ? '0 : bus.dividend;
      else if (state_q == FIX && !bus.kill)
        result_q <= fix_result;
    end
  end

  always_ff @(posedge ACLK) begin
    if (accept) begin
      sel_rem_q <= bus.op[1];
      neg_quo_q <= is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
      neg_rem_q <= is_signed && bus.dividend[XLEN-1];
      dvs_mag_q <= cond_neg(bus.divisor,  is_signed && bus.divisor[XLEN-1]);
      quo_q     <= cond_neg(bus.dividend, is_signed && bus.dividend[XLEN-1]);
      rem_q     <= '0;
    end else if (state_q == CALC) begin
      rem_q <= step_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], step_ok};
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.valid  = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter -- directed self-checking bench for div_iter.
`timescale 1ns/1ps
module tb_div_iter;

  logic ACLK;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_iter_if #(.XLEN(32)) bus ();

  div_iter #(.XLEN(32)) dut (
    .ACLK  (ACLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current cycle (cycle 0), then check the
  // valid cycle, the result, busy throughout, and the idle cycle after.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_cyc, input string tag);
    int   cyc;
    logic busy_ok;
    busy_ok      = 1'b1;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.valid && cyc < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      step();
      cyc++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    chk({tag, " valid_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
    step();
    chk({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " valid_after"}, {31'd0, bus.valid}, 32'd0);
  endtask

  initial begin
    int nv;
    int vcyc;
    RESET        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.kill     = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset busy",   {31'd0, bus.busy},  32'd0);
    chk("reset valid",  {31'd0, bus.valid}, 32'd0);
    chk("reset result", bus.result,         32'h0);
    RESET = 1'b1;
    step();

    // Signed and unsigned normal path
    run_op(2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
    run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        34, "rem_7_m2");
    run_op(2'b01, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 34, "divu_max_2");
    run_op(2'b11, 32'hFFFFFFFF, 32'd2,        32'd1,        34, "remu_max_2");
    run_op(2'b00, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 34, "div_m100_7");
    run_op(2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34, "rem_m100_7");

    // Divide by zero
    run_op(2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_5_0");
    run_op(2'b11, 32'd5, 32'd0, 32'd5,        1, "remu_5_0");
    run_op(2'b01, 32'd0, 32'd0, 32'hFFFFFFFF, 1, "divu_0_0");
    run_op(2'b10, 32'd0, 32'd0, 32'd0,        1, "rem_0_0");

    // Signed overflow; unsigned view of the same bits is an ordinary divide
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, "divu_ovf_bits");
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "remu_ovf_bits");

    // Kill in cycle 10: idle in cycle 11, no valid, result kept (0x80000000)
    bus.start    = 1'b1;
    bus.op       = 2'b00;
    bus.dividend = 32'h12345678;
    bus.divisor  = 32'd3;
    step();
    bus.start = 1'b0;
    nv = 0;
    for (int c = 1; c < 10; c++) begin
      if (bus.valid) nv++;
      step();
    end
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    chk("kill busy",   {31'd0, bus.busy},  32'd0);
    chk("kill valid",  {31'd0, bus.valid}, 32'd0);
    chk("kill result", bus.result,         32'h80000000);
    chk("kill no_valid_before", 32'(nv),   32'd0);
    run_op(2'b00, 32'd100, 32'd7, 32'd14, 34, "div_after_kill");

    // kill together with start in IDLE drops the request
    bus.start    = 1'b1;
    bus.kill     = 1'b1;
    bus.op       = 2'b00;
    bus.dividend = 32'd5;
    bus.divisor  = 32'd0;
    step();
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("kill_start busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("kill_start valid",  {31'd0, bus.valid}, 32'd0);
    chk("kill_start result", bus.result,         32'd14);

    // start held high for the whole request: accepted once only
    bus.start    = 1'b1;
    bus.op       = 2'b01;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd10;
    step();
    nv   = 0;
    vcyc = 0;
    for (int c = 1; c <= 34; c++) begin
      if (bus.valid) begin
        nv++;
        vcyc = c;
      end
      if (c == 34) bus.start = 1'b0;
      else step();
    end
    step();
    chk("held_start valid_count", 32'(nv),   32'd1);
    chk("held_start valid_cycle", 32'(vcyc), 32'd34);
    chk("held_start result", bus.result, 32'd100);
    chk("held_start busy_35", {31'd0, bus.busy}, 32'd0);
    step();
    chk("held_start busy_36", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in cycle 20 of a request
    bus.start    = 1'b1;
    bus.op       = 2'b10;
    bus.dividend = 32'd12345;
    bus.divisor  = 32'd11;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    RESET = 1'b0;
    #1;
    chk("async_rst busy",   {31'd0, bus.busy},  32'd0);
    chk("async_rst valid",  {31'd0, bus.valid}, 32'd0);
    chk("async_rst result", bus.result,         32'd0);
    step();
    RESET = 1'b1;
    step();
    run_op(2'b00, 32'd100, 32'd7, 32'd14, 34, "div_100_7");
    run_op(2'b10, 32'd100, 32'd7, 32'd2,  34, "rem_100_7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
